// File: rtl/gpu_mem_pkg.sv
// Shared constants, bank FSM encoding and address helpers for the per-bank
// memory controllers.
package gpu_mem_pkg;

    localparam int unsigned NUM_CORES = 16;
    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned BANK_MSB  = 11;
    localparam int unsigned BANK_LSB  = 8;
    localparam int unsigned WORD_W    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bank_state_t;

    function automatic logic [ADDR_W-1:0] core_addr(
        input logic [NUM_CORES*ADDR_W-1:0] addrs,
        input logic [3:0]                  i
    );
        return addrs[ADDR_W*i +: ADDR_W];
    endfunction

endpackage

// File: rtl/bank_sram.sv
// 256-word single-port synchronous SRAM with a registered read port.
// Contents are never reset.
module bank_sram #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [7:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [256];

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/bank_ctrl.sv
// Per-bank access controller: serves the core offered by the round-robin
// selector when it targets this bank, one SRAM read or write per service.
module bank_ctrl
    import gpu_mem_pkg::*;
#(
    parameter int unsigned BANK_ID = 0,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [3:0]                  core_cnt,
    input  logic [NUM_CORES-1:0]        core_val,
    input  logic [NUM_CORES*ADDR_W-1:0] bank_addr,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [3:0]                  bank_num,
    output logic                        core_serv,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]           rdata
);

    localparam logic [3:0] BANK_SEL = 4'(BANK_ID);

    bank_state_t       state, state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic              hit;
    logic [3:0]        idx_q;
    logic [3:0]        last_idx_q;
    logic              block_vld_q;
    logic [WORD_W-1:0] word_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              sram_en;
    logic [DATA_W-1:0] sram_rdata;

    assign bank_num = BANK_SEL;
    assign cur_addr = core_addr(bank_addr, core_cnt);

    // The just-served core stays blocked for one IDLE cycle so a requester
    // still dropping core_val cannot be captured twice.
    assign hit = ~reset
               & core_val[core_cnt]
               & (cur_addr[BANK_MSB:BANK_LSB] == BANK_SEL)
               & ~(block_vld_q & (core_cnt == last_idx_q));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        core_serv = 1'b0;
        core_ack  = '0;
        sram_en   = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    core_serv = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                core_serv = ~reset;
                sram_en   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (!reset) begin
                    core_ack[idx_q] = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q       <= '0;
            last_idx_q  <= '0;
            block_vld_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    block_vld_q <= 1'b0;
                    if (hit) begin
                        idx_q <= core_cnt;
                    end
                end
                RESP: begin
                    last_idx_q  <= idx_q;
                    block_vld_q <= 1'b1;
                    if (!we_q) begin
                        rdata_q <= sram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == IDLE && hit) begin
            word_q  <= cur_addr[WORD_W-1:0];
            we_q    <= core_we[core_cnt];
            wdata_q <= core_wdata[DATA_W*core_cnt +: DATA_W];
        end
    end

    // Read data is shown straight from the SRAM during RESP and held afterwards.
    always_comb begin
        rdata = rdata_q;
        if (reset) begin
            rdata = '0;
        end else if (state == RESP && !we_q) begin
            rdata = sram_rdata;
        end
    end

    bank_sram #(
        .DATA_W(DATA_W)
    ) u_sram (
        .clock (clock),
        .en    (sram_en),
        .we    (we_q),
        .addr  (word_q),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_bank_ctrl.sv
// Self-checking bench for bank_ctrl (BANK_ID = 3) driven by a simple rotating
// selector or a directly forced core_cnt.
`timescale 1ns/1ps
module tb_bank_ctrl;

    localparam int unsigned BANK = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   core_cnt;
    logic [3:0]   sel = '0;
    logic [3:0]   cnt_drv = '0;
    logic         use_sel = 1'b1;
    logic [15:0]  core_val = '0;
    logic [15:0]  core_we = '0;
    logic [191:0] bank_addr = '0;
    logic [255:0] core_wdata = '0;
    logic [3:0]   bank_num;
    logic         core_serv;
    logic [15:0]  core_ack;
    logic [15:0]  rdata;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    bank_ctrl #(
        .BANK_ID(BANK),
        .DATA_W (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .core_cnt   (core_cnt),
        .core_val   (core_val),
        .bank_addr  (bank_addr),
        .core_we    (core_we),
        .core_wdata (core_wdata),
        .bank_num   (bank_num),
        .core_serv  (core_serv),
        .core_ack   (core_ack),
        .rdata      (rdata)
    );

    always #5 clock = ~clock;

    assign core_cnt = use_sel ? sel : cnt_drv;

    // Round-robin selector: advances whenever the bank does not hold it.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) sel <= '0;
        else if (!core_serv) sel <= sel + 4'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-timestamp model: a capture at cycle T holds the selector in
    // T and T+1, acks in T+2, and blocks the same core in T+3.
    int          m_cap = -100;
    int          m_idx = 0;
    bit          m_we = 1'b0;
    logic [7:0]  m_word = '0;
    logic [15:0] m_wdata = '0;
    logic [15:0] m_last = '0;
    bit          m_known = 1'b1;
    logic [15:0] mmem [256];
    bit          mknown [256];
    int          ack_c;
    logic [11:0] fld;
    bit          blk, m_hit, e_serv;
    logic [15:0] e_ack, e_rd;

    always @(negedge clock) begin
        if (chk_en) begin
            ack_c  = m_cap + 2;
            fld    = bank_addr[12*core_cnt +: 12];
            blk    = (cyc == ack_c + 1) && (int'(core_cnt) == m_idx);
            m_hit  = !reset && (cyc > ack_c) && core_val[core_cnt] && (fld[11:8] == 4'(BANK)) && !blk;
            e_serv = !reset && (m_hit || cyc == m_cap + 1);
            e_ack  = (!reset && cyc == ack_c) ? (16'd1 << m_idx) : 16'd0;
            if (!reset && cyc == ack_c && !m_we) begin
                m_last  = mmem[m_word];
                m_known = mknown[m_word];
            end
            e_rd = reset ? 16'd0 : m_last;
            check("bank_num", 32'(bank_num), BANK);
            check("core_serv", 32'(core_serv), 32'(e_serv));
            check("core_ack", 32'(core_ack), 32'(e_ack));
            if (reset || m_known) check("rdata", 32'(rdata), 32'(e_rd));
            if (cyc == m_cap + 1 && m_we) begin
                mmem[m_word]   = m_wdata;
                mknown[m_word] = 1'b1;
            end
            if (reset) begin
                m_cap   = -100;
                m_last  = '0;
                m_known = 1'b1;
            end else if (m_hit) begin
                m_cap   = cyc;
                m_idx   = int'(core_cnt);
                m_we    = core_we[core_cnt];
                m_word  = fld[7:0];
                m_wdata = core_wdata[16*core_cnt +: 16];
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int c, input bit we, input logic [11:0] addr, input logic [15:0] wd);
        core_val[c] = 1'b1;
        core_we[c] = we;
        bank_addr[12*c +: 12] = addr;
        core_wdata[16*c +: 16] = wd;
    endtask

    task automatic wait_ack(input int maxc, output logic [15:0] got, output int at);
        got = '0;
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            if (core_ack != 16'd0) begin
                got = core_ack;
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got, first_ack;
        int t0, t1, t2, n1, n9, ta1, ta9, s0;
        bit prev_ack;
        int q[$];

        // Reset with a pending write from core 0
        for (int i = 0; i < 256; i++) mknown[i] = 1'b0;
        set_req(0, 1'b1, 12'h305, 16'h1111);
        @(negedge clock);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_serv", 32'(core_serv), 32'd0);
            check("rst_ack", 32'(core_ack), 32'd0);
            check("rst_rdata", 32'(rdata), 32'd0);
        end
        tick();
        reset = 1'b0;
        t0 = cyc;
        wait_ack(10, got, t1);
        check("t1_ack", 32'(got), 32'h0001);
        check("t1_latency", t1 - t0, 32'd2);
        tick();
        core_val = '0;

        // Core 5 writes 0xBEEF to 0x3A7, inputs scrambled after capture, then reads back
        tick();
        use_sel = 1'b0;
        cnt_drv = 4'd5;
        set_req(5, 1'b1, 12'h3A7, 16'hBEEF);
        t0 = cyc;
        tick();
        core_val[5] = 1'b0;
        bank_addr[60 +: 12] = 12'h3FF;
        core_wdata[80 +: 16] = 16'h1234;
        wait_ack(10, got, t1);
        check("t2_wr_ack", 32'(got), 32'h0020);
        check("t2_wr_latency", t1 - t0, 32'd2);
        tick();
        set_req(5, 1'b0, 12'h3A7, 16'h0000);
        wait_ack(12, got, t2);
        check("t2_rd_ack", 32'(got), 32'h0020);
        check("t2_rd_data", 32'(rdata), 32'hBEEF);
        check("t2_rd_gap", 32'(t2 - t1 >= 3), 32'd1);
        tick();
        core_val = '0;

        // Core 2 addresses bank 4: never served, selector keeps rotating
        cnt_drv = 4'd2;
        set_req(2, 1'b0, 12'h4A7, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t3_serv", 32'(core_serv), 32'd0);
            check("t3_ack", 32'(core_ack), 32'd0);
        end
        tick();
        use_sel = 1'b1;
        @(negedge clock);
        s0 = int'(core_cnt);
        repeat (5) @(negedge clock);
        check("t3_rotate", 32'(core_cnt), 32'((s0 + 5) % 16));
        tick();
        core_val = '0;
        reset = 1'b1;

        // Cores 1 and 9 both read bank 3 through the selector
        tick();
        reset = 1'b0;
        set_req(1, 1'b0, 12'h3A7, 16'h0000);
        set_req(9, 1'b0, 12'h3A7, 16'h0000);
        n1 = 0; n9 = 0; ta1 = 0; ta9 = 0; first_ack = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            got = core_ack;
            if (got != 16'd0 && first_ack == 16'd0) first_ack = got;
            if (got == 16'h0002) begin n1++; ta1 = cyc; end
            if (got == 16'h0200) begin n9++; ta9 = cyc; end
            tick();
            core_val = core_val & ~got;
        end
        check("t4_first", 32'(first_ack), 32'h0002);
        check("t4_core1_count", n1, 32'd1);
        check("t4_core9_count", n9, 32'd1);
        check("t4_gap", ta9 - ta1, 32'd10);

        // Core 15 requests continuously: wrap to 0 after each ack, 18-cycle period
        core_val = '0;
        set_req(15, 1'b0, 12'h3A7, 16'h0000);
        prev_ack = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (prev_ack) check("t5_wrap", 32'(core_cnt), 32'd0);
            prev_ack = (core_ack != 16'd0);
            if (prev_ack) begin
                check("t5_ack", 32'(core_ack), 32'h8000);
                q.push_back(cyc);
            end
        end
        check("t5_ack_count", 32'(q.size() >= 2), 32'd1);
        for (int i = 1; i < q.size(); i++) check("t5_period", q[i] - q[i-1], 32'd18);
        tick();
        core_val = '0;

        // Reset during ACCESS of a read: dropped, then a fresh read returns stored data
        tick();
        use_sel = 1'b0;
        cnt_drv = 4'd5;
        set_req(5, 1'b0, 12'h3A7, 16'h0000);
        tick();
        reset = 1'b1;
        core_val[5] = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t6_no_ack", 32'(core_ack), 32'd0);
            check("t6_rdata_zero", 32'(rdata), 32'd0);
        end
        tick();
        set_req(5, 1'b0, 12'h3A7, 16'h0000);
        wait_ack(10, got, t1);
        check("t6_ack", 32'(got), 32'h0020);
        check("t6_rdata", 32'(rdata), 32'hBEEF);
        tick();
        core_val = '0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
